// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO for any depth >= 2, with a registered or
// fall-through output, occupancy count, level flags and sticky error flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_dv;

  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_rd_acc = rd_en & ~w_empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      // A new error in the clearing cycle is kept.
      r_ovf <= (wr_en & ~w_wr_acc) | (r_ovf & ~clr_err);
      r_udf <= (rd_en & w_empty) | (r_udf & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign w_dout = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_dv   = ~w_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_dout <= '0;
        r_dv   <= 1'b0;
      end else begin
        if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
        r_dv <= w_rd_acc;
      end
    end
    assign w_dout = r_dout;
    assign w_dv   = r_dv;
  end

  assign dout         = w_dout;
  assign dout_valid   = w_dv;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_cnt >= CW'(AF_THRESH));
  assign almost_empty = (r_cnt <= CW'(AE_THRESH));
  assign count        = r_cnt;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: vector table, corner sequences and randomized traffic
// against queue-based reference models for three FIFO configurations.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // a: DEPTH 6 registered (AF 5, AE 1)
  logic a_wr, a_rd, a_clr, a_dv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_cnt;
  // b: DEPTH 4 fall-through (AF 3, AE 1)
  logic b_wr, b_rd, b_clr, b_dv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_cnt;
  // c: DEPTH 8 registered (AF 5, AE 2)
  logic c_wr, c_rd, c_clr, c_dv, c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [7:0] c_din, c_dout;
  logic [3:0] c_cnt;

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(0)) u_a (
    .clk(clk), .reset(reset), .wr_en(a_wr), .din(a_din), .rd_en(a_rd),
    .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ov), .underflow(a_un), .clr_err(a_clr));

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_b (
    .clk(clk), .reset(reset), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
    .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ov), .underflow(b_un), .clr_err(b_clr));

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0),
                   .AF_THRESH(5), .AE_THRESH(2)) u_c (
    .clk(clk), .reset(reset), .wr_en(c_wr), .din(c_din), .rd_en(c_rd),
    .dout(c_dout), .dout_valid(c_dv), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
    .overflow(c_ov), .underflow(c_un), .clr_err(c_clr));

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    logic       f, e, af, ae, dv, ov, un;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] pk(int cnt, logic f, logic e, logic af,
                                     logic ae, logic dv, logic ov, logic un,
                                     logic [7:0] d);
    return {8'(cnt), 1'b0, f, e, af, ae, dv, ov, un, d, 8'h00};
  endfunction

  function automatic vec_t mk(logic wr, logic rd, logic clr, logic [7:0] din,
                              int cnt, logic f, logic e, logic af, logic ae,
                              logic dv, logic ov, logic un, logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.dv = dv;
    v.ov = ov; v.un = un; v.dout = dout;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st_a();
    return pk(a_cnt, a_full, a_empty, a_af, a_ae, a_dv, a_ov, a_un, a_dout);
  endfunction
  function automatic logic [31:0] st_b();
    return pk(b_cnt, b_full, b_empty, b_af, b_ae, b_dv, b_ov, b_un, b_dout);
  endfunction
  function automatic logic [31:0] st_c();
    return pk(c_cnt, c_full, c_empty, c_af, c_ae, c_dv, c_ov, c_un, c_dout);
  endfunction

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] exp_list [4];
  logic [7:0] d_a;
  logic       dv_a, ov_a, un_a, ov_b, un_b, rok, wok;
  int         pw;

  initial begin
    reset = 1'b1;
    {a_wr, a_rd, a_clr, b_wr, b_rd, b_clr, c_wr, c_rd, c_clr} = '0;
    a_din = '0; b_din = '0; c_din = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_a", st_a(), pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
    chk("reset_b", st_b(), pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
    chk("reset_c", st_c(), pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00));

    // wr rd clr din | cnt f e af ae dv ov un dout
    tbl.push_back(mk(1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h04, 4, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h05, 5, 0, 0, 1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h06, 6, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h07, 6, 1, 0, 1, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 5, 0, 0, 1, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 1, 0, 8'h02));
    tbl.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 1, 1, 0, 8'h03));
    tbl.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 1, 0, 8'h04));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, 8'h05));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h06));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h06));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 1, 8'h06));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h06));

    foreach (tbl[i]) begin
      a_wr = tbl[i].wr; a_rd = tbl[i].rd;
      a_clr = tbl[i].clr; a_din = tbl[i].din;
      step();
      chk($sformatf("vec%0d", i), st_a(),
          pk(tbl[i].cnt, tbl[i].f, tbl[i].e, tbl[i].af, tbl[i].ae,
             tbl[i].dv, tbl[i].ov, tbl[i].un, tbl[i].dout));
    end
    a_wr = 0; a_rd = 0; a_clr = 0;

    // pointer wrap through index 5 -> 0
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        a_wr = 1; a_din = 8'h10 + 8'(r * 4 + k);
        step();
      end
      a_wr = 0;
      for (int k = 0; k < 4; k++) begin
        a_rd = 1;
        step();
        chk($sformatf("wrap%0d", r * 4 + k), {23'd0, a_dv, a_dout},
            {23'd0, 1'b1, 8'h10 + 8'(r * 4 + k)});
      end
      a_rd = 0;
    end
    chk("wrap_empty", {31'd0, a_empty}, 32'd1);

    // fall-through latency and pop
    b_wr = 1; b_din = 8'hAA;
    step();
    b_wr = 0;
    chk("fwft_head", {b_dv, b_cnt, b_dout}, {1'b1, 3'd1, 8'hAA});
    step();
    chk("fwft_hold", {b_dv, b_dout}, {1'b1, 8'hAA});
    b_rd = 1;
    step();
    b_rd = 0;
    chk("fwft_pop", {b_empty, b_dv, b_dout}, {1'b1, 1'b0, 8'h00});

    // full with simultaneous read and write
    for (int k = 1; k <= 4; k++) begin
      b_wr = 1; b_din = 8'(k);
      step();
    end
    chk("b_full", {b_full, b_cnt, b_af}, {1'b1, 3'd4, 1'b1});
    b_wr = 1; b_rd = 1; b_din = 8'h5A;
    step();
    b_wr = 0; b_rd = 0;
    chk("full_rw", {b_full, b_cnt, b_ov, b_dout}, {1'b1, 3'd4, 1'b0, 8'h02});
    exp_list[0] = 8'h02; exp_list[1] = 8'h03;
    exp_list[2] = 8'h04; exp_list[3] = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), {b_dv, b_dout}, {1'b1, exp_list[k]});
      b_rd = 1;
      step();
      b_rd = 0;
    end
    chk("b_drained", {b_empty, b_dv, b_ov, b_un}, {1'b1, 1'b0, 1'b0, 1'b0});

    // empty with simultaneous read and write, then error clearing
    b_wr = 1; b_rd = 1; b_din = 8'h33;
    step();
    b_wr = 0; b_rd = 0;
    chk("empty_rw", {b_un, b_cnt, b_dout}, {1'b1, 3'd1, 8'h33});
    b_clr = 1; b_rd = 1;
    step();
    chk("clr_err", {b_un, b_empty}, {1'b0, 1'b1});
    step();
    chk("set_wins", {31'd0, b_un}, 32'd1);
    b_rd = 0;
    step();
    b_clr = 0;
    chk("clr_again", {31'd0, b_un}, 32'd0);

    // level thresholds on c
    for (int k = 1; k <= 8; k++) begin
      c_wr = 1; c_din = 8'(k);
      step();
      chk($sformatf("fill%0d", k), {c_cnt, c_af, c_ae, c_full},
          {4'(k), k >= 5, k <= 2, k == 8});
    end
    c_wr = 0;
    for (int k = 7; k >= 0; k--) begin
      c_rd = 1;
      step();
      chk($sformatf("empty%0d", k), {c_cnt, c_af, c_ae, c_empty},
          {4'(k), k >= 5, k <= 2, k == 0});
    end
    c_rd = 0;
    for (int k = 1; k <= 6; k++) begin
      c_wr = 1; c_din = 8'(8'h40 + k);
      step();
    end
    c_wr = 0;
    chk("pre_reset", {c_cnt, c_dout}, {4'd6, 8'h08});
    #2 reset = 1'b1;
    #1;
    chk("async_rst", st_c(), pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
    @(posedge clk);
    #1 reset = 1'b0;

    // randomized traffic against queue models
    q_a.delete(); q_b.delete();
    d_a = 8'h00; dv_a = 0; ov_a = 0; un_a = 0; ov_b = 0; un_b = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      pw = ((cyc / 50) % 2 == 0) ? 70 : 30;
      a_wr = ($urandom_range(0, 99) < pw);
      a_rd = ($urandom_range(0, 99) < 100 - pw);
      a_din = 8'($urandom);
      a_clr = ($urandom_range(0, 15) == 0);
      b_wr = ($urandom_range(0, 99) < pw);
      b_rd = ($urandom_range(0, 99) < 100 - pw);
      b_din = 8'($urandom);
      b_clr = ($urandom_range(0, 15) == 0);

      rok = a_rd && q_a.size() > 0;
      wok = a_wr && (q_a.size() < 6 || rok);
      ov_a = (a_wr && !wok) || (ov_a && !a_clr);
      un_a = (a_rd && q_a.size() == 0) || (un_a && !a_clr);
      dv_a = rok;
      if (rok) d_a = q_a.pop_front();
      if (wok) q_a.push_back(a_din);

      rok = b_rd && q_b.size() > 0;
      wok = b_wr && (q_b.size() < 4 || rok);
      ov_b = (b_wr && !wok) || (ov_b && !b_clr);
      un_b = (b_rd && q_b.size() == 0) || (un_b && !b_clr);
      if (rok) void'(q_b.pop_front());
      if (wok) q_b.push_back(b_din);

      step();
      chk($sformatf("rnd_a%0d", cyc), st_a(),
          pk(q_a.size(), q_a.size() == 6, q_a.size() == 0, q_a.size() >= 5,
             q_a.size() <= 1, dv_a, ov_a, un_a, d_a));
      chk($sformatf("rnd_b%0d", cyc), st_b(),
          pk(q_b.size(), q_b.size() == 4, q_b.size() == 0, q_b.size() >= 3,
             q_b.size() <= 1, q_b.size() > 0, ov_b, un_b,
             (q_b.size() > 0) ? q_b[0] : 8'h00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
